wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- General-purpose register file: the consumer end of the MEM/WB write-back interface.
- Holds 32 architectural registers and commits one write-back per cycle.
- Serves two ID-stage operand read ports plus one debug read port.
- Provides WB→ID bypass, so an instruction in ID sees a value being written in the same cycle. No external forwarding path is needed for the WB→ID distance.

Parameters:
DATA_W, 32, register/data width (matches WORD_BUS)
ADDR_W, 5, register index width (matches REG_BUS)
REG_NUM, 32, number of architectural registers (2**ADDR_W)
BYPASS, 1, 1 = same-cycle write→read bypass enabled; 0 = reads return stored value only

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
wb_regDest  input  ADDR_W  write-back destination index; 0 = no write
wb_value  input  DATA_W  write-back data
id_rs  input  ADDR_W  operand A read index
id_rt  input  ADDR_W  operand B read index
id_rsValue  output  DATA_W  operand A data
id_rtValue  output  DATA_W  operand B data
dbg_idx  input  ADDR_W  debug read index
dbg_value  output  DATA_W  debug read data (no bypass)
wb_count  output  16  count of committed non-zero-destination writes

Behaviour:
- Reset (rst=0, async):
  - All REG_NUM registers clear to 0 immediately, without waiting for a clock edge.
  - wb_count clears to 0.
  - Read outputs show 0 combinationally while reset is held.
  - Writes are ignored while rst=0.
  - Release is synchronous-safe: the first write commits on the first rising edge with rst=1.
- Write:
  - On posedge clk with rst=1 and wb_regDest≠0: regs[wb_regDest] ← wb_value; wb_count ← wb_count+1.
  - wb_count wraps modulo 2^16: 0xFFFF → 0x0000.
  - wb_regDest=0: no storage change and no count increment; wb_value is ignored.
- Register 0:
  - Hard-wired zero; never written.
  - Any read of index 0 returns 0 regardless of bypass.
- Read ports A/B (combinational, zero latency):
  - If idx=0 → 0.
  - Else if BYPASS=1 and idx=wb_regDest (non-zero) → wb_value.
  - Else → regs[idx].
- Both ports may address the same index; both then return identical data.
- Debug port returns regs[dbg_idx] (0 for index 0) and never bypasses, so it reflects committed state only.
- Latency: a write presented in cycle N is visible on A/B in cycle N (bypass) and on the debug port from cycle N+1.
- Writes to the same index on consecutive cycles: the last write wins. Bypass always reflects the current cycle's wb_value.
- Reset asserted mid-operation: state is cleared regardless of pending write-back; the in-flight write is lost.

Decomposition:
- Shared constants stay in define.v: REG_BUS, WORD_BUS, ZERO_WORD, REG_ZERO (5'd0), RST_ENABLE (1'b0 for this block).
- No typedef package is needed.
- One natural sub-module: wb_regfile_rdport, the per-port zero/bypass/storage mux, instantiated twice with bypass and once with bypass disabled.

Test Plan:
- Reset then read: rst=0 for 3 cycles, release; id_rs=5, id_rt=31, dbg_idx=7 → all outputs 0x00000000, wb_count=0.
- Write/readback: wb_regDest=3, wb_value=0xDEADBEEF for 1 cycle, then wb_regDest=0 → from the next cycle id_rs=3 gives 0xDEADBEEF, dbg_idx=3 gives 0xDEADBEEF, wb_count=1.
- Bypass:
  - Same cycle, wb_regDest=8, wb_value=0x12345678, id_rs=8, id_rt=8 → both read 0x12345678 in that cycle.
  - dbg_idx=8 shows the old value (0) until the next edge.
- Zero register: wb_regDest=0, wb_value=0xFFFFFFFF; id_rs=0 → reads 0, storage unchanged, wb_count unchanged.
- Back-to-back overwrite: writes of 0x1 then 0x2 to reg 10 on consecutive cycles → reg 10 = 0x2, wb_count +2.
- Async reset mid-stream: reg 4 = 0xA5A5A5A5, wb_count = 0xFFFF (counter wrap check first: one more write → 0x0000); assert rst between edges → reg 4 and wb_count read 0 immediately; a write presented during reset does not commit.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared constants and types for the write-back register file.
package wb_regfile_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned REG_NUM = 1 << ADDR_W;
    localparam int unsigned CNT_W   = 16;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [CNT_W-1:0]  wb_cnt_t;

    localparam reg_idx_t REG_ZERO   = '0;
    localparam word_t    ZERO_WORD  = '0;
    localparam logic     RST_ENABLE = 1'b0;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB write-back, ID operand read and debug read signals of the register file.
interface wb_regfile_if;
    import wb_regfile_pkg::*;

    reg_idx_t wb_regDest;
    word_t    wb_value;
    reg_idx_t id_rs;
    reg_idx_t id_rt;
    word_t    id_rsValue;
    word_t    id_rtValue;
    reg_idx_t dbg_idx;
    word_t    dbg_value;
    wb_cnt_t  wb_count;

    modport master (
        output wb_regDest, wb_value, id_rs, id_rt, dbg_idx,
        input  id_rsValue, id_rtValue, dbg_value, wb_count
    );

    modport slave (
        input  wb_regDest, wb_value, id_rs, id_rt, dbg_idx,
        output id_rsValue, id_rtValue, dbg_value, wb_count
    );

endinterface

// File: rtl/wb_regfile_rdport.sv
// One read port: zero-register, optional WB->ID bypass, then stored value.
module wb_regfile_rdport
    import wb_regfile_pkg::*;
#(
    parameter bit BYPASS = 1'b1
) (
    input  logic     rst,
    input  reg_idx_t idx,
    input  reg_idx_t wb_dest,
    input  word_t    wb_value,
    input  word_t    stored,
    output word_t    rd_data_c
);

    // Reset forces zero so a write-back presented during reset cannot leak through bypass.
    always_comb begin
        rd_data_c = ZERO_WORD;
        if (rst == RST_ENABLE || idx == REG_ZERO) begin
            rd_data_c = ZERO_WORD;
        end else if (BYPASS && (wb_dest == idx)) begin
            rd_data_c = wb_value;
        end else begin
            rd_data_c = stored;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// 32-entry general-purpose register file: commits one write-back per cycle,
// serves two bypassed ID operand ports and one committed-state debug port.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter bit BYPASS = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);

    word_t   regs [REG_NUM];
    wb_cnt_t wb_count_q;

    logic wr_en_c;
    assign wr_en_c = (bus.wb_regDest != REG_ZERO);

    // Entry 0 is cleared on reset and never written, keeping it hard-wired to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < int'(REG_NUM); i++) begin
                regs[i] <= ZERO_WORD;
            end
        end else if (wr_en_c) begin
            regs[bus.wb_regDest] <= bus.wb_value;
        end
    end

    // Commit counter wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            wb_count_q <= '0;
        end else if (wr_en_c) begin
            wb_count_q <= wb_count_q + CNT_W'(1);
        end
    end

    assign bus.wb_count = wb_count_q;

    wb_regfile_rdport #(.BYPASS(BYPASS)) u_rd_rs (
        .rst       (rst),
        .idx       (bus.id_rs),
        .wb_dest   (bus.wb_regDest),
        .wb_value  (bus.wb_value),
        .stored    (regs[bus.id_rs]),
        .rd_data_c (bus.id_rsValue)
    );

    wb_regfile_rdport #(.BYPASS(BYPASS)) u_rd_rt (
        .rst       (rst),
        .idx       (bus.id_rt),
        .wb_dest   (bus.wb_regDest),
        .wb_value  (bus.wb_value),
        .stored    (regs[bus.id_rt]),
        .rd_data_c (bus.id_rtValue)
    );

    // Debug port never bypasses: it shows committed state only.
    wb_regfile_rdport #(.BYPASS(1'b0)) u_rd_dbg (
        .rst       (rst),
        .idx       (bus.dbg_idx),
        .wb_dest   (bus.wb_regDest),
        .wb_value  (bus.wb_value),
        .stored    (regs[bus.dbg_idx]),
        .rd_data_c (bus.dbg_value)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
module tb_wb_regfile;
    import wb_regfile_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    wb_regfile_if bus ();

    wb_regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input reg_idx_t dest, input word_t val);
        bus.wb_regDest = dest;
        bus.wb_value   = val;
        step();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst            = 1'b0;
        bus.wb_regDest = 5'd0;
        bus.wb_value   = 32'h0;
        bus.id_rs      = 5'd0;
        bus.id_rt      = 5'd0;
        bus.dbg_idx    = 5'd0;

        // Reset held for 3 cycles, then released away from the edge
        step(); step(); step();
        check("rst_held_count", 32'(bus.wb_count), 32'h0);
        rst = 1'b1;
        bus.id_rs   = 5'd5;
        bus.id_rt   = 5'd31;
        bus.dbg_idx = 5'd7;
        #1;
        check("rst_rs5", bus.id_rsValue, 32'h0);
        check("rst_rt31", bus.id_rtValue, 32'h0);
        check("rst_dbg7", bus.dbg_value, 32'h0);
        check("rst_count", 32'(bus.wb_count), 32'h0);

        // Write then readback
        write(5'd3, 32'hDEADBEEF);
        bus.wb_regDest = 5'd0;
        bus.wb_value   = 32'h0;
        bus.id_rs      = 5'd3;
        bus.dbg_idx    = 5'd3;
        #1;
        check("wr_rs3", bus.id_rsValue, 32'hDEADBEEF);
        check("wr_dbg3", bus.dbg_value, 32'hDEADBEEF);
        check("wr_count1", 32'(bus.wb_count), 32'h1);

        // Same-cycle bypass on both ports; debug still shows committed value
        bus.wb_regDest = 5'd8;
        bus.wb_value   = 32'h12345678;
        bus.id_rs      = 5'd8;
        bus.id_rt      = 5'd8;
        bus.dbg_idx    = 5'd8;
        #1;
        check("byp_rs8", bus.id_rsValue, 32'h12345678);
        check("byp_rt8", bus.id_rtValue, 32'h12345678);
        check("byp_dbg8_old", bus.dbg_value, 32'h0);
        step();
        bus.wb_regDest = 5'd0;
        #1;
        check("byp_dbg8_new", bus.dbg_value, 32'h12345678);
        check("byp_count2", 32'(bus.wb_count), 32'h2);

        // Register 0 is never written or counted
        bus.wb_regDest = 5'd0;
        bus.wb_value   = 32'hFFFFFFFF;
        bus.id_rs      = 5'd0;
        bus.id_rt      = 5'd3;
        bus.dbg_idx    = 5'd0;
        #1;
        check("zero_rs_same_cycle", bus.id_rsValue, 32'h0);
        step();
        check("zero_rs", bus.id_rsValue, 32'h0);
        check("zero_dbg", bus.dbg_value, 32'h0);
        check("zero_rt3_kept", bus.id_rtValue, 32'hDEADBEEF);
        check("zero_count", 32'(bus.wb_count), 32'h2);

        // Back-to-back overwrite of reg 10
        bus.id_rs   = 5'd10;
        bus.dbg_idx = 5'd10;
        write(5'd10, 32'h1);
        bus.wb_value = 32'h2;
        #1;
        check("b2b_dbg_first", bus.dbg_value, 32'h1);
        check("b2b_rs_bypass", bus.id_rsValue, 32'h2);
        step();
        bus.wb_regDest = 5'd0;
        #1;
        check("b2b_dbg_last", bus.dbg_value, 32'h2);
        check("b2b_count4", 32'(bus.wb_count), 32'h4);

        // Fill counter to 0xFFFE, then reg 4 write brings it to 0xFFFF
        for (int i = 0; i < 65530; i++) begin
            write(5'd20, 32'(i));
        end
        write(5'd4, 32'hA5A5A5A5);
        bus.wb_regDest = 5'd0;
        bus.dbg_idx    = 5'd4;
        #1;
        check("fill_count_ffff", 32'(bus.wb_count), 32'h0000FFFF);
        check("fill_dbg4", bus.dbg_value, 32'hA5A5A5A5);
        bus.dbg_idx = 5'd20;
        #1;
        check("fill_dbg20", bus.dbg_value, 32'd65529);
        write(5'd20, 32'h0);
        bus.wb_regDest = 5'd0;
        bus.dbg_idx    = 5'd4;
        #1;
        check("wrap_count0", 32'(bus.wb_count), 32'h0);
        check("wrap_dbg4_kept", bus.dbg_value, 32'hA5A5A5A5);

        // Async reset between edges with a write in flight
        bus.wb_regDest = 5'd4;
        bus.wb_value   = 32'h00001234;
        bus.id_rs      = 5'd4;
        #1;
        check("pre_rst_bypass", bus.id_rsValue, 32'h00001234);
        rst = 1'b0;
        #1;
        check("arst_dbg4", bus.dbg_value, 32'h0);
        check("arst_rs4", bus.id_rsValue, 32'h0);
        check("arst_count", 32'(bus.wb_count), 32'h0);
        step();
        check("arst_no_commit", bus.dbg_value, 32'h0);
        check("arst_no_count", 32'(bus.wb_count), 32'h0);

        // Release: first edge with rst high commits
        rst = 1'b1;
        bus.wb_value = 32'h00000077;
        step();
        bus.wb_regDest = 5'd0;
        #1;
        check("rel_dbg4", bus.dbg_value, 32'h00000077);
        check("rel_count1", 32'(bus.wb_count), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
